// File: rtl/calendar_counter.sv
// calendar_counter
// ----------------
// Timekeeping core for the century clock. A prescaler divides clk down to
// one-second ticks, and each tick advances a seconds/minutes/hours/day/
// month/year cascade over a 00-99 century. While setup_en is high the count
// is frozen and the front panel can step any single field with setup_inc.
//
// Optional feature (compile-time macro):
//   CALENDAR_LEAP_YEAR_EN - when defined, February has 29 days in years whose
//                           two low bits are zero (year 00 counts as leap).
//                           When undefined, February always has 28 days.
//
// Parameters:
//   TICKS_PER_SEC - clk cycles per second (>= 2)
//   PRESCALE_W    - prescaler width, 2**PRESCALE_W >= TICKS_PER_SEC
//
// Ports:
//   clk          - system clock, rising-edge active
//   rst          - asynchronous reset, active low
//   setup_en     - pause timekeeping and enable field setup
//   setup_sel    - field to set: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year
//   setup_inc    - increment request, acted on at its rising edge
//   sec, min     - 0..59
//   hour         - 0..23
//   day          - 1..days in current month
//   month        - 1..12
//   year         - 0..99
//   sec_tick     - one-cycle pulse alongside each timekeeping second step
//   century_wrap - one-cycle pulse when the year rolls from 99 to 0

module calendar_counter #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESCALE_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_en,
    input  logic [2:0] setup_sel,
    input  logic       setup_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       sec_tick,
    output logic       century_wrap
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] prescaler;
    logic [PRESCALE_W-1:0] prescaler_next;
    logic                  setup_inc_q;

    logic [5:0] sec_next;
    logic [5:0] min_next;
    logic [4:0] hour_next;
    logic [4:0] day_next;
    logic [3:0] month_next;
    logic [6:0] year_next;

    logic [4:0] dim;
    logic       tick;
    logic       inc_edge;
    logic       wr_sec, wr_min, wr_hour, wr_day, wr_month, wr_year;
    logic       t_min, t_hour, t_day, t_month, t_year, t_wrap;

    // Length of the current month. February depends on the leap option.
    always_comb begin
        dim = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2: begin
`ifdef CALENDAR_LEAP_YEAR_EN
                dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
                dim = 5'd28;
`endif
            end
            default: dim = 5'd31;
        endcase
    end

    // Tick detection, setup write decoding and the carry chain. A tick can
    // only happen with setup_en low and a setup write only with it high,
    // so the two never compete for a field on the same edge.
    always_comb begin
        tick     = !setup_en && (prescaler == PRESCALE_MAX);
        inc_edge = setup_inc && !setup_inc_q;

        wr_sec   = setup_en && inc_edge && (setup_sel == 3'd0);
        wr_min   = setup_en && inc_edge && (setup_sel == 3'd1);
        wr_hour  = setup_en && inc_edge && (setup_sel == 3'd2);
        wr_day   = setup_en && inc_edge && (setup_sel == 3'd3);
        wr_month = setup_en && inc_edge && (setup_sel == 3'd4);
        wr_year  = setup_en && inc_edge && (setup_sel == 3'd5);

        t_min   = tick && (sec == 6'd59);
        t_hour  = t_min && (min == 6'd59);
        t_day   = t_hour && (hour == 5'd23);
        t_month = t_day && (day >= dim);
        t_year  = t_month && (month == 4'd12);
        t_wrap  = t_year && (year == 7'd99);
    end

    // Next-state values for every field. The same wrap arithmetic serves
    // both the tick cascade and a setup increment; setup just never carries.
    // A day left beyond the month length by a month/year change is pulled
    // back to the last valid day on the following edge.
    always_comb begin
        prescaler_next = prescaler;
        sec_next       = sec;
        min_next       = min;
        hour_next      = hour;
        day_next       = day;
        month_next     = month;
        year_next      = year;

        if (setup_en) begin
            if (wr_sec) begin
                prescaler_next = '0;
            end
        end else if (prescaler == PRESCALE_MAX) begin
            prescaler_next = '0;
        end else begin
            prescaler_next = prescaler + PRESCALE_ONE;
        end

        if (tick || wr_sec) begin
            sec_next = (sec >= 6'd59) ? 6'd0 : sec + 6'd1;
        end
        if (t_min || wr_min) begin
            min_next = (min >= 6'd59) ? 6'd0 : min + 6'd1;
        end
        if (t_hour || wr_hour) begin
            hour_next = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
        end
        if (t_day || wr_day) begin
            day_next = (day >= dim) ? 5'd1 : day + 5'd1;
        end else if (day > dim) begin
            day_next = dim;
        end
        if (t_month || wr_month) begin
            month_next = (month >= 4'd12) ? 4'd1 : month + 4'd1;
        end
        if (t_year || wr_year) begin
            year_next = (year >= 7'd99) ? 7'd0 : year + 7'd1;
        end
    end

    // State register. The setup_inc history is updated every cycle so that
    // an ignored press still counts as "seen" and cannot fire later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler    <= '0;
            setup_inc_q  <= 1'b0;
            sec          <= 6'd0;
            min          <= 6'd0;
            hour         <= 5'd0;
            day          <= 5'd1;
            month        <= 4'd1;
            year         <= 7'd0;
            sec_tick     <= 1'b0;
            century_wrap <= 1'b0;
        end else begin
            prescaler    <= prescaler_next;
            setup_inc_q  <= setup_inc;
            sec          <= sec_next;
            min          <= min_next;
            hour         <= hour_next;
            day          <= day_next;
            month        <= month_next;
            year         <= year_next;
            sec_tick     <= tick;
            century_wrap <= t_wrap;
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// Testbench for calendar_counter with TICKS_PER_SEC = 10.
// Each scenario task drives its own directed stimulus and compares the DUT
// against hand-computed values.

module tb_calendar_counter;

    logic       clk;
    logic       rst;
    logic       setup_en;
    logic [2:0] setup_sel;
    logic       setup_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic       sec_tick;
    logic       century_wrap;

    int tests_run;
    int tests_failed;

    calendar_counter #(
        .TICKS_PER_SEC(10),
        .PRESCALE_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .setup_en    (setup_en),
        .setup_sel   (setup_sel),
        .setup_inc   (setup_inc),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day         (day),
        .month       (month),
        .year        (year),
        .sec_tick    (sec_tick),
        .century_wrap(century_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        setup_inc = 1'b0;
        setup_sel = 3'd0;
        step(2);
        rst = 1'b1;
    endtask

    // n clean press/release cycles on the selected field.
    task automatic pulse_field(input logic [2:0] sel, input int n);
        setup_sel = sel;
        repeat (n) begin
            setup_inc = 1'b1;
            step(1);
            setup_inc = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        setup_en = 1'b0;
        do_reset();
        tests_run++;
        if ({hour, min, sec, day, month, year, sec_tick, century_wrap} !==
            {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 7'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got %0d:%0d:%0d d%0d m%0d y%0d tick%0b wrap%0b, expected 0:0:0 d1 m1 y0 tick0 wrap0",
                     hour, min, sec, day, month, year, sec_tick, century_wrap);
        end
        step(9);
        tests_run++;
        if ({sec, sec_tick} !== {6'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL first_tick_early: got sec=%0d tick=%0b, expected sec=0 tick=0", sec, sec_tick);
        end
        step(1);
        tests_run++;
        if ({sec, sec_tick} !== {6'd1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL first_tick: got sec=%0d tick=%0b, expected sec=1 tick=1", sec, sec_tick);
        end
        step(1);
        tests_run++;
        if (sec_tick !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tick_width: got tick=%0b, expected 0", sec_tick);
        end
        // Asynchronous reset in the middle of a cycle.
        step(15);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({sec, day, month} !== {6'd0, 5'd1, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got sec=%0d d%0d m%0d, expected sec=0 d1 m1", sec, day, month);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_full_cascade();
        setup_en = 1'b1;
        do_reset();
        pulse_field(3'd4, 11);
        pulse_field(3'd3, 30);
        pulse_field(3'd5, 99);
        pulse_field(3'd2, 23);
        pulse_field(3'd1, 59);
        pulse_field(3'd0, 59);
        tests_run++;
        if ({hour, min, sec, day, month, year, sec_tick} !==
            {5'd23, 6'd59, 6'd59, 5'd31, 4'd12, 7'd99, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL cascade_preset: got %0d:%0d:%0d d%0d m%0d y%0d tick%0b, expected 23:59:59 d31 m12 y99 tick0",
                     hour, min, sec, day, month, year, sec_tick);
        end
        setup_en = 1'b0;
        step(9);
        tests_run++;
        if ({sec, sec_tick, century_wrap} !== {6'd59, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL cascade_pre_tick: got sec=%0d tick=%0b wrap=%0b, expected 59 0 0", sec, sec_tick, century_wrap);
        end
        step(1);
        tests_run++;
        if ({hour, min, sec, day, month, year, sec_tick, century_wrap} !==
            {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 7'd0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL cascade_rollover: got %0d:%0d:%0d d%0d m%0d y%0d tick%0b wrap%0b, expected 0:0:0 d1 m1 y0 tick1 wrap1",
                     hour, min, sec, day, month, year, sec_tick, century_wrap);
        end
        step(1);
        tests_run++;
        if ({sec_tick, century_wrap} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL cascade_pulse_width: got tick=%0b wrap=%0b, expected 0 0", sec_tick, century_wrap);
        end
    endtask

    task automatic test_leap_year();
        setup_en = 1'b1;
        do_reset();
        pulse_field(3'd5, 4);
        pulse_field(3'd4, 1);
        pulse_field(3'd3, 27);
        pulse_field(3'd2, 23);
        pulse_field(3'd1, 59);
        pulse_field(3'd0, 59);
        setup_en = 1'b0;
        step(10);
`ifdef CALENDAR_LEAP_YEAR_EN
        tests_run++;
        if ({day, month, year, hour} !== {5'd29, 4'd2, 7'd4, 5'd0}) begin
            tests_failed++;
            $display("[TB] FAIL leap_feb28: got d%0d m%0d y%0d h%0d, expected d29 m2 y4 h0", day, month, year, hour);
        end
        setup_en = 1'b1;
        pulse_field(3'd2, 23);
        pulse_field(3'd1, 59);
        pulse_field(3'd0, 59);
        setup_en = 1'b0;
        step(10);
        tests_run++;
        if ({hour, min, sec, day, month, year} !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd3, 7'd4}) begin
            tests_failed++;
            $display("[TB] FAIL leap_feb29: got %0d:%0d:%0d d%0d m%0d y%0d, expected 0:0:0 d1 m3 y4",
                     hour, min, sec, day, month, year);
        end
`else
        tests_run++;
        if ({day, month, year, hour} !== {5'd1, 4'd3, 7'd4, 5'd0}) begin
            tests_failed++;
            $display("[TB] FAIL noleap_feb28: got d%0d m%0d y%0d h%0d, expected d1 m3 y4 h0", day, month, year, hour);
        end
`endif
    endtask

    task automatic test_setup_wrap_ignore();
        setup_en = 1'b1;
        do_reset();
        pulse_field(3'd1, 59);
        pulse_field(3'd1, 1);
        tests_run++;
        if ({min, hour, sec_tick} !== {6'd0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL min_wrap: got min=%0d hour=%0d tick=%0b, expected 0 0 0", min, hour, sec_tick);
        end
        setup_sel = 3'd1;
        setup_inc = 1'b1;
        step(5);
        setup_inc = 1'b0;
        step(1);
        tests_run++;
        if (min !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL held_inc: got min=%0d, expected 1", min);
        end
        pulse_field(3'd7, 3);
        tests_run++;
        if ({hour, min, sec, day, month, year} !== {5'd0, 6'd1, 6'd0, 5'd1, 4'd1, 7'd0}) begin
            tests_failed++;
            $display("[TB] FAIL sel7_ignored: got %0d:%0d:%0d d%0d m%0d y%0d, expected 0:1:0 d1 m1 y0",
                     hour, min, sec, day, month, year);
        end
        setup_en = 1'b0;
        pulse_field(3'd1, 1);
        tests_run++;
        if (min !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL inc_without_setup: got min=%0d, expected 1", min);
        end
    endtask

    task automatic test_day_clamp();
        setup_en = 1'b1;
        do_reset();
        pulse_field(3'd5, 1);
        pulse_field(3'd3, 30);
        setup_sel = 3'd4;
        setup_inc = 1'b1;
        step(1);
        tests_run++;
        if ({month, day} !== {4'd2, 5'd31}) begin
            tests_failed++;
            $display("[TB] FAIL clamp_month_step: got m%0d d%0d, expected m2 d31", month, day);
        end
        setup_inc = 1'b0;
        step(1);
        tests_run++;
        if ({month, day, year} !== {4'd2, 5'd28, 7'd1}) begin
            tests_failed++;
            $display("[TB] FAIL clamp_day: got m%0d d%0d y%0d, expected m2 d28 y1", month, day, year);
        end
    endtask

    task automatic test_pause_resume();
        int ticks_seen;
        setup_en = 1'b0;
        do_reset();
        step(9);
        setup_en = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sec_tick) ticks_seen++;
        end
        tests_run++;
        if ({ticks_seen[7:0], sec} !== {8'd0, 6'd0}) begin
            tests_failed++;
            $display("[TB] FAIL pause_no_tick: got ticks=%0d sec=%0d, expected 0 0", ticks_seen, sec);
        end
        setup_en = 1'b0;
        step(1);
        tests_run++;
        if ({sec, sec_tick} !== {6'd1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL resume_tick: got sec=%0d tick=%0b, expected 1 1", sec, sec_tick);
        end
        setup_en = 1'b1;
        pulse_field(3'd0, 1);
        setup_en = 1'b0;
        step(9);
        tests_run++;
        if ({sec, sec_tick} !== {6'd2, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL sec_set_prescale_early: got sec=%0d tick=%0b, expected 2 0", sec, sec_tick);
        end
        step(1);
        tests_run++;
        if ({sec, sec_tick} !== {6'd3, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL sec_set_prescale_tick: got sec=%0d tick=%0b, expected 3 1", sec, sec_tick);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        setup_en     = 1'b0;
        setup_sel    = 3'd0;
        setup_inc    = 1'b0;
        test_reset();
        test_full_cascade();
        test_leap_year();
        test_setup_wrap_ignore();
        test_day_clamp();
        test_pause_resume();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/calendar_counter.md
# calendar_counter

Parametrised timekeeping core for the century clock: it divides the system clock down to one-second ticks and maintains a full seconds/minutes/hours/day/month/year count over a 100-year (00–99) century, with optional leap-year handling. It replaces the fixed seconds-only counter chain. It sits between the board clock and the display/swap logic, which reads its binary fields and converts them to BCD and seven-segment codes. A field-select setup port lets the front panel set any field while timekeeping is paused.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second. Must be ≥ 2.
- `PRESCALE_W`, default 26: prescaler width. Must satisfy 2^PRESCALE_W ≥ TICKS_PER_SEC.
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset. **Asynchronous, active-low.**
- `setup_en` input, 1 bit: setup mode. When high, timekeeping is paused and setup is enabled.
- `setup_sel` input, 3 bits: selects the field to set. 0 = sec, 1 = min, 2 = hour, 3 = day, 4 = month, 5 = year; 6 and 7 are ignored.
- `setup_inc` input, 1 bit: increment request, taken on its rising edge; level synchronous to clk.
- `sec` output, 6 bits: 0–59.
- `min` output, 6 bits: 0–59.
- `hour` output, 5 bits: 0–23.
- `day` output, 5 bits: 1–days_in_month.
- `month` output, 4 bits: 1–12.
- `year` output, 7 bits: 0–99.
- `sec_tick` output, 1 bit: one-cycle pulse on every timekeeping second increment.
- `century_wrap` output, 1 bit: one-cycle pulse when year wraps from 99 to 0.

## Operation
- **Reset values:** prescaler 0, sec 0, min 0, hour 0, day 1, month 1, year 0, sec_tick 0, century_wrap 0, setup_inc edge register 0.
- **Prescaler:** counts 0 to TICKS_PER_SEC−1 while setup_en is low. The wrap cycle is the tick.
- **Cascade on tick:**
  - sec+1. At 59 it goes to 0 and carries to min.
  - min 59→0 carries to hour.
  - hour 23→0 carries to day.
  - day at days_in_month → 1, carries to month.
  - month 12→1 carries to year.
  - year 99→0 asserts century_wrap.
  - All affected fields update on the same edge.
- **days_in_month:** 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for 4, 6, 9, 11; 28 for February, or 29 per Configuration.
- **Setup mode (setup_en = 1):**
  - The prescaler holds its value.
  - A setup_inc rising edge (registered 0→1) increments the selected field by 1, wrapping within its legal range with no carry into other fields: sec/min 59→0, hour 23→0, day max→1, month 12→1, year 99→0.
  - Incrementing sec also clears the prescaler to 0.
  - setup_inc edges are ignored when setup_en is low or setup_sel is 6 or 7. The edge register still tracks setup_inc in those cases.
- **Day clamp:** if day exceeds days_in_month after a month or year change, day is forced to days_in_month on the next edge, e.g. 31 Jan → Feb gives 28 or 29.
- **Exiting setup:** counting resumes from the held prescaler value. There is no extra tick.

## Timing
- Tick latency: fields change on the edge where the prescaler equals TICKS_PER_SEC−1. sec_tick is high for the one cycle following that edge, coincident with the new field values.
- century_wrap is high in the same cycle as the sec_tick that produced year 0.
- Setup latency: setup_inc sampled high (previous sample low) → the field changes on that same edge, i.e. visible one cycle after setup_inc is presented.
- Setup writes never assert sec_tick or century_wrap.
- setup_en high in a cycle where the prescaler is at TICKS_PER_SEC−1: setup wins. No tick, and the prescaler holds.
- Day clamp is one cycle after the month/year change. No tick can occur during setup, so clamp and tick never coincide.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first tick after reset release is TICKS_PER_SEC cycles later.

## Configuration
- `CALENDAR_LEAP_YEAR_EN`:
  - Defined: February has 29 days when year[1:0] == 0, so year 00 (2000) is leap. Otherwise 28.
  - Undefined: February always has 28 days, and the leap logic is absent.

## Test plan
- **Reset:** rst low for 2 cycles, then high with TICKS_PER_SEC = 10 → outputs 0:00:00 on day 1, month 1, year 0. First sec_tick arrives exactly 10 cycles after release, with sec = 1.
- **Full cascade:** preset via setup to 23:59:59, 31 Dec, year 99, then release setup → after one second: 00:00:00, 1 Jan, year 0. sec_tick and century_wrap both pulse for exactly one cycle.
- **Leap year:** preset 23:59:59, 28 Feb, year 4 → with `CALENDAR_LEAP_YEAR_EN` the count goes to 29 Feb; without it, to 1 Mar. From 29 Feb 23:59:59 (macro defined) → 1 Mar.
- **Setup wrap and ignore:**
  - setup_sel = 1, min = 59, one setup_inc pulse → min = 0 and hour unchanged.
  - Holding setup_inc high for 5 cycles → only one increment.
  - setup_sel = 7 → no change.
  - setup_en low → no change.
- **Day clamp:** day = 31, month = 1, setup_sel = 4, one setup_inc pulse → month = 2, then day = 28 one cycle later (year 1).
- **Pause and resume:** assert setup_en at prescaler = 9 of 10 → no tick while high. After deassert, the tick occurs 1 cycle later. Setting sec resets the prescaler, so the next tick comes a full 10 cycles after setup exit.
